// File: rtl/bytewrite_ram.sv
// Single-port byte-writable word RAM with registered read data (1-cycle latency).
// Optional out-of-range/misalignment blocking enabled by macro BYTEWRITE_RAM_RANGE_CHECK_EN.
module bytewrite_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_WORDS  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o,
  output logic                    err_o
);

  localparam int NB_BYTES = DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(NUM_WORDS);
  localparam int OFF_W    = $clog2(NB_BYTES);

  logic [NB_BYTES-1:0][7:0] mem [NUM_WORDS];

  logic [IDX_W-1:0]    idx;
  logic                blocked;
  logic                accept_read;
  logic [NB_BYTES-1:0] lane_we;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  rvalid_reg;

  assign idx         = addr_i[IDX_W+OFF_W-1:OFF_W];
  assign accept_read = en_i && (we_i == '0);

`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(NUM_WORDS * NB_BYTES);

  logic err_reg;

  assign blocked = ({1'b0, addr_i} >= MEM_BYTES) || (addr_i[OFF_W-1:0] != '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= en_i && blocked;
    end
  end

  assign err_o = err_reg;
`else
  // Offset and high address bits are intentionally dropped: accesses wrap.
  logic unused_addr;
  assign unused_addr = ^{addr_i[OFF_W-1:0], addr_i[ADDR_WIDTH-1:IDX_W+OFF_W]};
  assign blocked     = 1'b0;
  assign err_o       = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NB_BYTES; gi++) begin : g_lane
      assign lane_we[gi] = en_i && we_i[gi] && !blocked;
    end
  endgenerate

  // Array has no reset so it maps onto byte-enable block RAM.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB_BYTES; k++) begin
      if (rstn_i && lane_we[k]) begin
        mem[idx][k] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= accept_read;
      if (accept_read) begin
        rdata_reg <= blocked ? '0 : mem[idx];
      end
    end
  end

  assign rdata_o  = rdata_reg;
  assign rvalid_o = rvalid_reg;

endmodule

// File: tb/tb_bytewrite_ram.sv
// Self-checking bench for bytewrite_ram: word-level reference model checked every cycle,
// plus directed literal expectations. Honours BYTEWRITE_RAM_RANGE_CHECK_EN if defined.
module tb_bytewrite_ram;

  localparam int NW        = 1024;
  localparam int MEM_BYTES = NW * 4;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        en   = 1'b0;
  logic [3:0]  we   = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  int checks = 0;
  int errors = 0;

  bytewrite_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(NW)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as plain words, per-byte "written" mask.
  logic [31:0] m_mem [NW];
  logic [3:0]  m_kb  [NW];
  logic [31:0] exp_rdata  = 32'h0;
  bit          exp_rvalid = 1'b0;
  bit          exp_err    = 1'b0;
  bit          exp_known  = 1'b1;

  initial for (int i = 0; i < NW; i++) m_kb[i] = 4'h0;

  function automatic int widx(input logic [31:0] a);
    return int'((a % MEM_BYTES) / 4);
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
    return (a >= MEM_BYTES) || (a % 4 != 0);
`else
    return (a != a);
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (w[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_rdata  <= 32'h0;
      exp_rvalid <= 1'b0;
      exp_err    <= 1'b0;
      exp_known  <= 1'b1;
    end else begin
      exp_rvalid <= en && (we == 4'h0);
      exp_err    <= en && bad_addr(addr);
      if (en && we == 4'h0) begin
        if (bad_addr(addr)) begin
          exp_rdata <= 32'h0;
          exp_known <= 1'b1;
        end else begin
          exp_rdata <= m_mem[widx(addr)];
          exp_known <= (m_kb[widx(addr)] == 4'hF);
        end
      end else if (en && !bad_addr(addr)) begin
        m_mem[widx(addr)] <= merge(m_mem[widx(addr)], wdata, we);
        m_kb[widx(addr)]  <= m_kb[widx(addr)] | we;
      end
    end
  end

  always @(negedge clk) begin
    check("rvalid", {31'h0, rvalid}, {31'h0, exp_rvalid});
    check("err", {31'h0, err}, {31'h0, exp_err});
    if (exp_known) check("rdata", rdata, exp_rdata);
  end

  task automatic op(input bit e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    op(1, 4'hF, 32'h10, 32'hDEADBEEF);
    op(1, 4'h0, 32'h10, 32'h0);
    check("full_word", rdata, 32'hDEADBEEF);
    check("full_word_rvalid", {31'h0, rvalid}, 32'h1);
    op(0, 4'h0, 32'h10, 32'h0);
    check("idle_rvalid", {31'h0, rvalid}, 32'h0);
    check("idle_hold", rdata, 32'hDEADBEEF);

    op(1, 4'h1, 32'h10, 32'h000000AA);
    op(1, 4'h8, 32'h10, 32'h55000000);
    op(1, 4'h0, 32'h10, 32'h0);
    check("byte_lanes", rdata, 32'h55ADBEAA);

    op(1, 4'hF, 32'h20, 32'h0);
    op(1, 4'hC, 32'h20, 32'h12345678);
    op(1, 4'h0, 32'h20, 32'h0);
    check("halfword", rdata, 32'h12340000);
    op(1, 4'h0, 32'h22, 32'h0);
    check("b2b_rvalid", {31'h0, rvalid}, 32'h1);
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
    check("unaligned_blocked", rdata, 32'h0);
    check("unaligned_err", {31'h0, err}, 32'h1);
`else
    check("unaligned_same_word", rdata, 32'h12340000);
`endif

    op(1, 4'hF, 32'h04, 32'hFFFFFFFC);
    op(1, 4'h0, 32'h04, 32'h0);
    check("raw_neg4", rdata, 32'hFFFFFFFC);
    op(0, 4'h0, 32'h0, 32'h0);
    check("raw_hold", rdata, 32'hFFFFFFFC);
    check("raw_hold_rvalid", {31'h0, rvalid}, 32'h0);

    op(1, 4'hF, 32'h0, 32'h11111111);
    op(1, 4'hF, 32'h1000, 32'hCAFEF00D);
    op(1, 4'h0, 32'h0, 32'h0);
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
    check("range_word0", rdata, 32'h11111111);
`else
    check("wrap_word0", rdata, 32'hCAFEF00D);
`endif
    op(1, 4'h0, 32'h80000010, 32'h0);
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
    check("high_addr_blocked", rdata, 32'h0);
    check("high_addr_err", {31'h0, err}, 32'h1);
`else
    check("high_addr_wrap", rdata, 32'h55ADBEAA);
    check("high_addr_err", {31'h0, err}, 32'h0);
`endif

    // Async reset while a read result is being presented.
    op(1, 4'h0, 32'h10, 32'h0);
    en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_rvalid", {31'h0, rvalid}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    op(1, 4'h0, 32'h10, 32'h0);
    check("mem_kept", rdata, 32'h55ADBEAA);

    for (int i = 0; i < 16; i++) op(1, 4'hF, 32'(i * 4), $urandom);
    for (int i = 0; i < 150; i++) begin
      op($urandom_range(0, 3) != 0,
         ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
         32'($urandom_range(0, 63)), $urandom);
    end
    op(0, 4'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
